// File: rtl/operand_stack_pkg.sv
// rtl/operand_stack_pkg.sv - shared CPU constants and stack sizing defaults
//   Purpose: default stack geometry plus opcode prefixes and ALU op encodings
//            used across the multicycle stack CPU datapath.
//   Ports:   none (package).
package operand_stack_pkg;

   localparam int STK_WIDTH = 8;
   localparam int STK_DEPTH = 16;

   // Instruction opcode prefixes (top three bits of the instruction word)
   localparam logic [2:0] OPC_PUSH = 3'b100;
   localparam logic [2:0] OPC_JMP  = 3'b110;
   localparam logic [2:0] OPC_JZ   = 3'b111;
   localparam logic [2:0] OPC_ALU0 = 3'b000;
   localparam logic [2:0] OPC_ALU3 = 3'b011;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - DEPTH x WIDTH storage, sync write, async read
//   Purpose: backing storage for the operand stack; contents are not reset.
//   Ports:   clk            rising-edge clock
//            we/waddr/wdata synchronous write port
//            raddr -> rdata asynchronous read port
module stack_regfile #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - hardware operand stack for the multicycle stack CPU
//   Purpose: responds to push/pop/tos strobes from the controller; holds the
//            stack pointer, occupancy count, registered dout and sticky errors.
//   Ports:   clk, rst (async, active-high)
//            push/pop/tos strobes, din push data, clr_err clears error flags
//            dout registered top/popped value, count occupancy,
//            empty/full derived from count, err_ovf/err_unf sticky errors
import operand_stack_pkg::*;

module operand_stack #(
   parameter int WIDTH = STK_WIDTH,
   parameter int DEPTH = STK_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     tos,
   input  logic [WIDTH-1:0]         din,
   input  logic                     clr_err,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     err_ovf,
   output logic                     err_unf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [AW-1:0]    r_sp;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_dout;
   logic             r_err_ovf;
   logic             r_err_unf;

   logic             w_empty;
   logic             w_full;
   logic [AW-1:0]    w_top;
   logic [WIDTH-1:0] w_rdata;
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [AW-1:0]    w_sp_nxt;
   logic [AW:0]      w_cnt_nxt;
   logic             w_load_dout;
   logic             w_set_ovf;
   logic             w_set_unf;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);
   assign w_top   = r_sp - 1'b1;

   // Priority decode: push&pop (replace top) > pop > tos/push. tos is evaluated
   // against the pre-push top because the read port is asynchronous and the
   // write only lands at the clock edge.
   always_comb begin
      w_we        = 1'b0;
      w_waddr     = r_sp;
      w_sp_nxt    = r_sp;
      w_cnt_nxt   = r_count;
      w_load_dout = 1'b0;
      w_set_ovf   = 1'b0;
      w_set_unf   = 1'b0;
      if (push && pop && !w_empty) begin
         w_we        = 1'b1;
         w_waddr     = w_top;
         w_load_dout = 1'b1;
      end else if (pop && !push) begin
         if (!w_empty) begin
            w_load_dout = 1'b1;
            w_sp_nxt    = w_top;
            w_cnt_nxt   = r_count - 1'b1;
         end else begin
            w_set_unf = 1'b1;
         end
      end else begin
         // Reaching here with pop set means push&pop on an empty stack:
         // the pop is dropped (and tos with it) and flagged.
         if (pop) begin
            w_set_unf = 1'b1;
         end else if (tos) begin
            if (!w_empty) w_load_dout = 1'b1;
            else          w_set_unf   = 1'b1;
         end
         if (push) begin
            if (!w_full) begin
               w_we      = 1'b1;
               w_sp_nxt  = r_sp + 1'b1;
               w_cnt_nxt = r_count + 1'b1;
            end else begin
               w_set_ovf = 1'b1;
            end
         end
      end
   end

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (din),
      .raddr (w_top),
      .rdata (w_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sp      <= '0;
         r_count   <= '0;
         r_dout    <= '0;
         r_err_ovf <= 1'b0;
         r_err_unf <= 1'b0;
      end else begin
         r_sp      <= w_sp_nxt;
         r_count   <= w_cnt_nxt;
         if (w_load_dout) r_dout <= w_rdata;
         // A new error in the same cycle as clr_err keeps the flag set.
         r_err_ovf <= w_set_ovf | (r_err_ovf & ~clr_err);
         r_err_unf <= w_set_unf | (r_err_unf & ~clr_err);
      end
   end

   assign dout    = r_dout;
   assign count   = r_count;
   assign empty   = w_empty;
   assign full    = w_full;
   assign err_ovf = r_err_ovf;
   assign err_unf = r_err_unf;

endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - scoreboard testbench for operand_stack
module tb_operand_stack;

   localparam int W = 8;
   localparam int D = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         push = 1'b0, pop = 1'b0, tos = 1'b0, clr_err = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] dout;
   logic [4:0]   count;
   logic         empty, full, err_ovf, err_unf;

   operand_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
      .clr_err(clr_err), .dout(dout), .count(count), .empty(empty),
      .full(full), .err_ovf(err_ovf), .err_unf(err_unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] dout;
      int           count;
      bit           ovf;
      bit           unf;
   } exp_t;

   exp_t         exp_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;

   // reference model state
   logic [W-1:0] m_stk[$];
   logic [W-1:0] m_dout;
   bit           m_ovf, m_unf;

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_stk.delete();
      m_dout = '0;
      m_ovf  = 0;
      m_unf  = 0;
   endtask

   // Behavioural reference: stack as a queue, rules straight from the
   // operation table.
   task automatic model_step(input bit p, input bit q, input bit t,
                             input logic [W-1:0] d, input bit c);
      bit set_o = 0, set_u = 0;
      int n = m_stk.size();
      if (p && q && n > 0) begin
         m_dout = m_stk[n-1];
         m_stk[n-1] = d;
      end else if (q && !p) begin
         if (n > 0) m_dout = m_stk.pop_back();
         else       set_u = 1;
      end else begin
         if (q) set_u = 1;
         else if (t) begin
            if (n > 0) m_dout = m_stk[n-1];
            else       set_u = 1;
         end
         if (p) begin
            if (n < D) m_stk.push_back(d);
            else       set_o = 1;
         end
      end
      m_ovf = set_o || (m_ovf && !c);
      m_unf = set_u || (m_unf && !c);
   endtask

   task automatic step(input bit p, input bit q, input bit t,
                       input logic [W-1:0] d, input bit c);
      exp_t e;
      @(negedge clk);
      push = p; pop = q; tos = t; din = d; clr_err = c;
      model_step(p, q, t, d, c);
      e.dout = m_dout; e.count = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic do_push(input logic [W-1:0] d); step(1, 0, 0, d, 0); endtask
   task automatic do_pop();  step(0, 1, 0, '0, 0); endtask
   task automatic do_tos();  step(0, 0, 1, '0, 0); endtask
   task automatic do_idle(); step(0, 0, 0, '0, 0); endtask

   // Monitor: every cycle the stack registers a strobe set, compare against
   // the expected state queued by the driver.
   always @(posedge clk) begin
      #1;
      if (!rst && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("sb_dout",  int'(dout),    int'(e.dout));
         chk("sb_count", int'(count),   e.count);
         chk("sb_empty", int'(empty),   int'(e.count == 0));
         chk("sb_full",  int'(full),    int'(e.count == D));
         chk("sb_ovf",   int'(err_ovf), int'(e.ovf));
         chk("sb_unf",   int'(err_unf), int'(e.unf));
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_dout"},  int'(dout),    0);
      chk({tag, "_count"}, int'(count),   0);
      chk({tag, "_empty"}, int'(empty),   1);
      chk({tag, "_full"},  int'(full),    0);
      chk({tag, "_ovf"},   int'(err_ovf), 0);
      chk({tag, "_unf"},   int'(err_unf), 0);
   endtask

   initial begin
      int wait_cnt;
      model_reset();
      #12;
      check_reset_outputs("rst0");
      @(negedge clk);
      rst = 1'b0;

      // basic LIFO
      do_push(8'h11); do_push(8'h22); do_push(8'h33);
      chk("cnt3", int'(count), 3);
      do_tos();
      chk("tos33", int'(dout), 'h33);
      chk("tos_cnt", int'(count), 3);
      do_pop(); chk("pop33", int'(dout), 'h33);
      do_pop(); chk("pop22", int'(dout), 'h22);
      do_pop(); chk("pop11", int'(dout), 'h11);
      chk("lifo_empty", int'(empty), 1);

      // fill and overflow
      for (int i = 0; i < D; i++) do_push(8'(i));
      chk("fill_full", int'(full), 1);
      do_push(8'hAA);
      chk("ovf_flag", int'(err_ovf), 1);
      chk("ovf_cnt", int'(count), 16);
      do_pop();
      chk("ovf_pop", int'(dout), 'h0F);
      for (int i = 0; i < D - 1; i++) do_pop();

      // underflow, clear, clear-vs-new-error
      do_pop();
      chk("unf_flag", int'(err_unf), 1);
      chk("unf_hold", int'(dout), 'h00);
      step(0, 0, 0, '0, 1);
      chk("unf_clr", int'(err_unf), 0);
      step(0, 0, 1, '0, 1);
      chk("unf_clr_win", int'(err_unf), 1);
      step(0, 0, 0, '0, 1);

      // replace-top
      do_push(8'h05); do_push(8'h07);
      step(1, 1, 0, 8'h0C, 0);
      chk("rep_dout", int'(dout), 'h07);
      chk("rep_cnt", int'(count), 2);
      do_pop();
      chk("rep_pop", int'(dout), 'h0C);
      do_pop();

      // ALU-style sequence
      do_push(8'd3); do_push(8'd4);
      do_tos(); chk("alu_tos", int'(dout), 4);
      do_pop(); chk("alu_pop4", int'(dout), 4);
      do_pop(); chk("alu_pop3", int'(dout), 3);
      chk("alu_cnt0", int'(count), 0);
      do_push(8'd7); chk("alu_cnt1", int'(count), 1);
      do_tos(); chk("alu_top7", int'(dout), 7);

      // push&pop on empty: push wins, underflow flagged
      do_pop();
      step(0, 0, 0, '0, 1);
      step(1, 1, 0, 8'h5A, 0);
      chk("pp_empty_cnt", int'(count), 1);
      chk("pp_empty_unf", int'(err_unf), 1);

      // randomized, alternating fill-biased and drain-biased phases
      for (int ph = 0; ph < 6; ph++) begin
         for (int i = 0; i < 300; i++) begin
            bit p, q, t, c;
            if (ph % 2 == 0) begin
               p = ($urandom_range(0, 99) < 70);
               q = ($urandom_range(0, 99) < 25);
            end else begin
               p = ($urandom_range(0, 99) < 25);
               q = ($urandom_range(0, 99) < 70);
            end
            t = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 7) == 0);
            step(p, q, t, 8'($urandom), c);
         end
      end
      do_idle();

      // async reset mid-cycle
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      model_reset();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      do_push(8'h99);
      chk("post_rst_cnt", int'(count), 1);
      do_tos();
      chk("post_rst_tos", int'(dout), 'h99);
      do_idle();

      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      #3;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
